// File: rtl/gearbox_pkg.sv
// Shared types and constants for the 24->32 gearbox frame scheduler.
// Four 24-bit words fill exactly three 32-bit words, so frames are padded to groups of four.
package gearbox_pkg;

  localparam int W_IN  = 24;
  localparam int W_OUT = 32;
  localparam int GROUP = 4;

  typedef enum logic [2:0] {IDLE, ARB, XFER, PAD, DRAIN, GAP} state_t;

  // True when the word at 0-based index cnt closes a 4-word group.
  function automatic logic grp_end(input int unsigned cnt);
    return (cnt % GROUP) == (GROUP - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer, wrapping. Purely combinational.
// Returns a one-hot grant, its index, and whether any request was present.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_j]) begin
        o_any       = 1'b1;
        o_idx       = w_j;
        o_gnt[w_j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gearbox_frame_sched.sv
// Shares one 24->32 gearbox among N framed sources: round-robin grant, pad frames to 4-word groups, idle gap after each.
// Output words appear one cycle after acceptance; s_ready only toward the granted source in XFER/DRAIN.
module gearbox_frame_sched #(
  parameter int N_SRC     = 4,
  parameter int MAX_WORDS = 256,
  parameter int GAP       = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [gearbox_pkg::W_IN*N_SRC-1:0]  s_data,
  input  logic [N_SRC-1:0]                    s_valid,
  input  logic [N_SRC-1:0]                    s_last,
  output logic [N_SRC-1:0]                    s_ready,
  output logic [gearbox_pkg::W_IN-1:0]        gb_data_in,
  output logic                                gb_data_en,
  output logic                                gb_last,
  output logic [$clog2(N_SRC)-1:0]            grant_id,
  output logic                                busy,
  output logic                                err_trunc
);
  import gearbox_pkg::*;

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_WORDS) + 1;
  localparam int GW = $clog2(GAP + 1);

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_ptr, w_ptr_nxt;
  logic [IW-1:0]     r_grant, w_grant_nxt;
  logic [N_SRC-1:0]  r_gnt_oh, w_gnt_oh_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [GW-1:0]     r_gap, w_gap_nxt;
  logic [W_IN-1:0]   r_dat, w_dat_nxt;
  logic              r_en, w_en_nxt;
  logic              r_last, w_last_nxt;
  logic              r_err, w_err_nxt;

  logic [N_SRC-1:0]  w_arb_gnt;
  logic [IW-1:0]     w_arb_idx;
  logic              w_arb_any;
  logic [W_IN-1:0]   w_sel_dat;
  logic              w_acc, w_lst, w_cnt_max;

  rr_arbiter #(.N(N_SRC), .IW(IW)) u_arb (
    .i_req (s_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  always_comb begin
    w_sel_dat = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_gnt_oh[i]) w_sel_dat = s_data[i*W_IN +: W_IN];
    end
  end

  assign s_ready   = (r_state == XFER || r_state == DRAIN) ? r_gnt_oh : '0;
  assign w_acc     = |(s_valid & s_ready);
  assign w_lst     = |(s_last & r_gnt_oh);
  assign w_cnt_max = (r_cnt == CW'(MAX_WORDS - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_grant_nxt  = r_grant;
    w_gnt_oh_nxt = r_gnt_oh;
    w_cnt_nxt    = r_cnt;
    w_gap_nxt    = '0;
    w_dat_nxt    = '0;
    w_en_nxt     = 1'b0;
    w_last_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      IDLE: if (|s_valid) w_state_nxt = ARB;
      ARB: begin
        w_cnt_nxt = '0;
        if (w_arb_any) begin
          w_grant_nxt  = w_arb_idx;
          w_gnt_oh_nxt = w_arb_gnt;
          w_state_nxt  = XFER;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      XFER: if (w_acc) begin
        w_dat_nxt = w_sel_dat;
        w_en_nxt  = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
        // The count limit lands on a group boundary because MAX_WORDS is a multiple of 4.
        if (w_cnt_max) begin
          w_last_nxt  = 1'b1;
          w_err_nxt   = !w_lst;
          w_state_nxt = w_lst ? gearbox_pkg::GAP : DRAIN;
        end else if (w_lst) begin
          w_last_nxt  = grp_end(int'(r_cnt));
          w_state_nxt = grp_end(int'(r_cnt)) ? gearbox_pkg::GAP : PAD;
        end
      end
      PAD: begin
        w_en_nxt  = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (grp_end(int'(r_cnt))) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = gearbox_pkg::GAP;
        end
      end
      DRAIN: if (w_acc && w_lst) w_state_nxt = gearbox_pkg::GAP;
      gearbox_pkg::GAP: begin
        if (r_gap == GW'(GAP - 1)) begin
          w_ptr_nxt   = (r_grant == IW'(N_SRC - 1)) ? '0 : r_grant + IW'(1);
          w_state_nxt = (|s_valid) ? ARB : IDLE;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_gnt_oh <= '0;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_dat    <= '0;
      r_en     <= 1'b0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_gnt_oh <= w_gnt_oh_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gap    <= w_gap_nxt;
      r_dat    <= w_dat_nxt;
      r_en     <= w_en_nxt;
      r_last   <= w_last_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign gb_data_in = r_dat;
  assign gb_data_en = r_en;
  assign gb_last    = r_last;
  assign err_trunc  = r_err;
  assign grant_id   = r_grant;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_gearbox_frame_sched.sv
// Directed and randomized frames against a frame-level model of grant order, padding, truncation and gaps.
module tb_gearbox_frame_sched;

  localparam int N    = 4;
  localparam int MAXW = 8;
  localparam int GAPC = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [24*N-1:0] s_data;
  logic [N-1:0]    s_valid, s_last, s_ready;
  logic [23:0]     gb_data_in;
  logic            gb_data_en, gb_last, busy, err_trunc;
  logic [1:0]      grant_id;

  gearbox_frame_sched #(.N_SRC(N), .MAX_WORDS(MAXW), .GAP(GAPC)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .gb_data_in (gb_data_in),
    .gb_data_en (gb_data_en),
    .gb_last    (gb_last),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_trunc  (err_trunc)
  );

  initial forever #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  logic [23:0] src_words[N][$];
  int          src_lens[N][$];
  int          pos[N];
  int          ph[N];
  int          mode = 0;
  bit          drive_en = 1'b0;
  int          m_ptr = 0;
  int          last_n_obs = 0;

  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  int          exp_g[$];
  int          obs_g[$];
  int          v_gap = 0, v_consec = 0, v_errlast = 0, v_rdy = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source drivers: first word of a frame is always offered, later words per mode.
  initial begin
    bit v;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (drive_en && src_lens[i].size() > 0) begin
          if (pos[i] > 0) ph[i]++;
          case (mode)
            0:       v = 1'b1;
            1:       v = (pos[i] == 0) || ($urandom_range(0, 2) != 0);
            default: v = (pos[i] == 0) || (ph[i] % 3 == 0);
          endcase
          s_valid[i]         = v;
          s_last[i]          = (pos[i] == src_lens[i][0] - 1);
          s_data[i*24 +: 24] = src_words[i][0];
        end else begin
          s_valid[i]         = 1'b0;
          s_last[i]          = 1'b0;
          s_data[i*24 +: 24] = '0;
        end
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst_n && s_valid[i] && s_ready[i]) begin
          void'(src_words[i].pop_front());
          pos[i]++;
          ph[i] = 0;
          if (pos[i] == src_lens[i][0]) begin
            void'(src_lens[i].pop_front());
            pos[i] = 0;
          end
        end
      end
    end
  end

  // Output monitor: records emitted words and protocol violations.
  initial begin
    bit prev_last = 1'b0;
    bit seen_last = 1'b0;
    int idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_last = 1'b0;
        seen_last = 1'b0;
        idle = 0;
      end else begin
        if (gb_data_en) begin
          obs_q.push_back({gb_last, err_trunc, gb_data_in});
          if (seen_last && idle < GAPC) v_gap++;
          seen_last = 1'b0;
          idle = 0;
        end else begin
          idle++;
        end
        if (gb_last) begin
          obs_g.push_back(int'(grant_id));
          seen_last = 1'b1;
          idle = 0;
        end
        if (gb_last && (prev_last || !gb_data_en)) v_consec++;
        if (err_trunc && !gb_last) v_errlast++;
        if ($countones(s_ready) > 1) v_rdy++;
        prev_last = gb_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame-level model: round-robin order, truncate at MAXW, pad to a multiple of 4.
  task automatic build_exp();
    int fi[N];
    int wi[N];
    int g, j, len, kept, tot;
    logic [23:0] d;
    bit lst, err;
    for (int i = 0; i < N; i++) begin fi[i] = 0; wi[i] = 0; end
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && fi[j] < src_lens[j].size()) g = j;
      end
      if (g < 0) break;
      len  = src_lens[g][fi[g]];
      kept = (len > MAXW) ? MAXW : len;
      tot  = (len > MAXW) ? MAXW : ((len + 3) / 4) * 4;
      for (int k = 0; k < tot; k++) begin
        d   = (k < kept) ? src_words[g][wi[g] + k] : 24'h0;
        lst = (k == tot - 1);
        err = lst && (len > MAXW);
        exp_q.push_back({lst, err, d});
      end
      exp_g.push_back(g);
      wi[g] += len;
      fi[g]++;
      m_ptr = (g + 1) % N;
    end
  endtask

  task automatic add_frame(input int s, input int len, input bit rnd, input logic [23:0] base);
    for (int k = 0; k < len; k++)
      src_words[s].push_back(rnd ? 24'($urandom) : base + 24'(k));
    src_lens[s].push_back(len);
  endtask

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete(); exp_g.delete(); obs_g.delete();
    v_gap = 0; v_consec = 0; v_errlast = 0; v_rdy = 0;
  endtask

  task automatic do_reset();
    drive_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_words[i].delete(); src_lens[i].delete(); pos[i] = 0; ph[i] = 0;
    end
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_obs();
  endtask

  task automatic run_and_check(input string tag);
    int  cyc = 0;
    bit  done = 1'b0;
    bit  empty;
    int  n;
    build_exp();
    drive_en = 1'b1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (src_lens[i].size() != 0) empty = 1'b0;
      if (empty && !busy) done = 1'b1;
    end
    @(negedge clk);
    drive_en = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_nwords"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
    chk({tag, "_nframes"}, obs_g.size(), exp_g.size());
    n = (obs_g.size() < exp_g.size()) ? obs_g.size() : exp_g.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_gnt%0d", tag, i), obs_g[i], exp_g[i]);
    chk({tag, "_gap_viol"}, v_gap, 0);
    chk({tag, "_last_viol"}, v_consec, 0);
    chk({tag, "_err_viol"}, v_errlast, 0);
    chk({tag, "_rdy_viol"}, v_rdy, 0);
    last_n_obs = obs_q.size();
    clear_obs();
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_en",   gb_data_en, 0);
    chk("rst_last", gb_last, 0);
    chk("rst_data", gb_data_in, 0);
    chk("rst_gid",  grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err",  err_trunc, 0);
    chk("rst_rdy",  s_ready, 0);

    do_reset();
    add_frame(0, 8, 1'b0, 24'h000001);
    run_and_check("t1");
    chk("t1_bits32", (last_n_obs * 24) / 32, 6);

    do_reset();
    add_frame(1, 5, 1'b0, 24'h000100);
    run_and_check("t2");
    chk("t2_en_cycles", last_n_obs, 8);

    do_reset();
    add_frame(0, 2, 1'b0, 24'h000010);
    add_frame(1, 3, 1'b0, 24'h000020);
    add_frame(2, 4, 1'b0, 24'h000030);
    add_frame(3, 1, 1'b0, 24'h000040);
    add_frame(0, 2, 1'b0, 24'h000050);
    run_and_check("t3");

    do_reset();
    add_frame(2, 11, 1'b0, 24'h000200);
    run_and_check("t4");

    do_reset();
    mode = 2;
    add_frame(3, 6, 1'b0, 24'h000300);
    add_frame(3, 1, 1'b0, 24'h000310);
    run_and_check("t5");
    mode = 0;

    do_reset();
    add_frame(0, 1, 1'b0, 24'hABCDEF);
    drive_en = 1'b1;
    cyc = 0;
    while (!gb_data_en && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_word", {gb_data_en, gb_data_in}, {1'b1, 24'hABCDEF});
    chk("t6_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en",   gb_data_en, 0);
    chk("t6_rst_last", gb_last, 0);
    chk("t6_rst_data", gb_data_in, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err",  err_trunc, 0);
    chk("t6_rst_gid",  grant_id, 0);
    chk("t6_rst_rdy",  s_ready, 0);
    drive_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    clear_obs();
    add_frame(0, 4, 1'b0, 24'h000400);
    run_and_check("t6b");

    do_reset();
    mode = 1;
    for (int r = 0; r < 5; r++) begin
      for (int s = 0; s < N; s++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) add_frame(s, $urandom_range(1, 12), 1'b1, 24'h0);
      end
      run_and_check($sformatf("rnd%0d", r));
    end
    mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
